// File: rtl/tlul_sram_responder.sv
// tlul_sram_responder
//   Device-side TL-UL responder. Terminates one crossbar device port and
//   turns A-channel Get / PutFullData / PutPartialData requests into
//   single-port SRAM accesses with a one-cycle read latency. Responses
//   (AccessAck / AccessAckData) go back in acceptance order through a small
//   response FIFO. a_ready is derived from FIFO occupancy plus the one
//   in-flight access, so it never depends combinationally on d_ready.
//
// Ports
//   clk_i    : clock, all state on posedge
//   rst_i    : synchronous, active-high reset
//   tl_i     : A channel from the crossbar plus d_ready
//   tl_o     : D channel to the crossbar plus a_ready
//   req_o    : SRAM access strobe, one cycle per accepted request
//   we_o     : 1 = write, 0 = read
//   addr_o   : SRAM word address (a_address[SramAw+1:2])
//   wdata_o  : write data
//   wmask_o  : bit write mask, a_mask byte lanes expanded to 8 bits each
//   rdata_i  : SRAM read data, valid the cycle after req_o
//
// Build option
//   TLUL_ERR_CHECK_EN : when defined, malformed requests (bad opcode, size,
//   alignment or mask) get d_error=1 and never touch the SRAM. When
//   undefined, every accepted request accesses the SRAM, unknown opcodes are
//   treated as reads and d_error is always 0.

package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_sram_responder
  import tlul_pkg::*;
#(
  parameter int SramAw   = 12,
  parameter int RspDepth = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       wmask_o,
  input  logic [31:0]       rdata_i
);

  localparam int CntW = $clog2(RspDepth + 1);
  localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;

  typedef struct packed {
    logic       data_rsp;
    logic [1:0] size;
    logic [7:0] source;
    logic       error;
  } meta_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        error;
  } rsp_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(RspDepth - 1)) return '0;
    return ptr + PtrW'(1);
  endfunction

  logic            is_put_p0;
  logic            data_rsp_p0;
  logic            err_p0;
  logic            a_ready_p0;
  logic            accept_p0;
  logic            vld_p1;
  meta_t           meta_p1;
  rsp_t            rsp_p1;
  logic [CntW-1:0] count;
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic            push;
  logic            pop;
  logic            d_valid;
  rsp_t            fifo_mem [RspDepth];
  rsp_t            head;
  logic            unused_bits;

  // Stage p0: request decode, credit check and SRAM strobe
  assign is_put_p0 = (tl_i.a_opcode == OpPutFull) || (tl_i.a_opcode == OpPutPartial);

`ifdef TLUL_ERR_CHECK_EN
  localparam logic [2:0] OpGet = 3'd4;

  // Byte lanes a legal access of this size/offset may touch.
  function automatic logic [3:0] lane_window(input logic [1:0] size, input logic [1:0] offs);
    case (size)
      2'd0:    lane_window = 4'b0001 << offs;
      2'd1:    lane_window = offs[1] ? 4'b1100 : 4'b0011;
      default: lane_window = 4'b1111;
    endcase
  endfunction

  logic [3:0] win_p0;
  logic       misalign_p0;

  always_comb begin
    win_p0      = lane_window(tl_i.a_size, tl_i.a_address[1:0]);
    misalign_p0 = ((tl_i.a_size == 2'd1) && tl_i.a_address[0]) ||
                  ((tl_i.a_size == 2'd2) && (tl_i.a_address[1:0] != 2'b00));
    err_p0      = !(is_put_p0 || (tl_i.a_opcode == OpGet)) ||
                  (tl_i.a_size == 2'd3) || misalign_p0 ||
                  ((tl_i.a_mask & ~win_p0) != 4'b0000) ||
                  ((tl_i.a_opcode == OpPutFull) && (tl_i.a_mask != win_p0));
    // Unknown opcodes answer with a plain AccessAck.
    data_rsp_p0 = (tl_i.a_opcode == OpGet);
  end
`else
  assign err_p0      = 1'b0;
  assign data_rsp_p0 = !is_put_p0;
`endif

  // Occupancy counts the in-flight access so a response always has a slot.
  assign a_ready_p0 = !rst_i && ((int'(count) + int'(vld_p1)) < RspDepth);
  assign accept_p0  = tl_i.a_valid && a_ready_p0;

  assign req_o   = accept_p0 && !err_p0;
  assign we_o    = req_o && is_put_p0;
  assign addr_o  = tl_i.a_address[SramAw+1:2];
  assign wdata_o = tl_i.a_data;

  always_comb begin
    wmask_o = '0;
    for (int i = 0; i < 4; i++) wmask_o[8*i +: 8] = {8{tl_i.a_mask[i]}};
  end

  // Stage p1: SRAM data returns, response entry formed
  always_ff @(posedge clk_i) begin
    if (rst_i) vld_p1 <= 1'b0;
    else       vld_p1 <= accept_p0;
  end

  always_ff @(posedge clk_i) begin
    if (accept_p0) begin
      meta_p1 <= '{data_rsp: data_rsp_p0, size: tl_i.a_size,
                   source: tl_i.a_source, error: err_p0};
    end
  end

  always_comb begin
    rsp_p1.opcode = meta_p1.data_rsp ? 3'd1 : 3'd0;
    rsp_p1.size   = meta_p1.size;
    rsp_p1.source = meta_p1.source;
    rsp_p1.data   = (meta_p1.data_rsp && !meta_p1.error) ? rdata_i : 32'h0;
    rsp_p1.error  = meta_p1.error;
  end

  // Stage p2: response FIFO and D channel
  assign push    = vld_p1;
  assign d_valid = !rst_i && (count != '0);
  assign pop     = d_valid && tl_i.d_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr] <= rsp_p1;
  end

  assign head = fifo_mem[rptr];

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = head.opcode;
    tl_o.d_size   = head.size;
    tl_o.d_source = head.source;
    tl_o.d_data   = head.data;
    tl_o.d_error  = head.error;
    tl_o.a_ready  = a_ready_p0;
  end

  // Fields the crossbar has already consumed or that carry no meaning here.
  assign unused_bits = ^{tl_i.a_param, tl_i.a_user,
                         tl_i.a_address[31:SramAw+2], tl_i.a_address[1:0]};

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Testbench for tlul_sram_responder: directed scenarios plus randomized
// traffic checked against a transaction-level model (reference memory and an
// ordered queue of expected responses).
module tb_tlul_sram_responder;
  import tlul_pkg::*;

  localparam int SramAw   = 12;
  localparam int RspDepth = 3;

  logic              clk = 1'b0;
  logic              rst;
  tl_h2d_t           tl_i;
  tl_d2h_t           tl_o;
  logic              req;
  logic              we;
  logic [SramAw-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       wmask;
  logic [31:0]       rdata;
  logic              init_mem;

  always #5 clk = ~clk;

  tlul_sram_responder #(.SramAw(SramAw), .RspDepth(RspDepth)) dut (
    .clk_i(clk), .rst_i(rst), .tl_i(tl_i), .tl_o(tl_o), .req_o(req), .we_o(we),
    .addr_o(addr), .wdata_o(wdata), .wmask_o(wmask), .rdata_i(rdata)
  );

  // Behavioural SRAM driven only by the DUT strobes.
  logic [31:0] sram [1 << SramAw];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < (1 << SramAw); i++) sram[i] <= 32'h0;
    end else if (req) begin
      if (we) sram[addr] <= (sram[addr] & ~wmask) | (wdata & wmask);
      else    rdata <= sram[addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [1 << SramAw];
  int          cyc = 0;
  int          n_acc = 0, n_beat = 0, n_stall = 0;
  int          beat_first = -1, beat_last = -1;
  logic [31:0] last_data, last_wmask;
  logic [2:0]  last_opc;
  logic        last_err, acc_req;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every accepted request is applied to ref_mem in order
  // and its response is queued; every D beat must match the queue head.
  always @(negedge clk) begin
    if (init_mem) for (int i = 0; i < (1 << SramAw); i++) ref_mem[i] = 32'h0;
    if (rst) begin
      exp_q.delete();
      chk("rst_a_ready", 32'(tl_o.a_ready), 0);
      chk("rst_d_valid", 32'(tl_o.d_valid), 0);
      chk("rst_req", 32'(req), 0);
    end else begin
      if (tl_o.d_valid && tl_i.d_ready) begin
        n_beat++;
        if (beat_first < 0) beat_first = cyc;
        beat_last = cyc;
        if (exp_q.size() == 0) begin
          chk("d_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("d_opcode", 32'(tl_o.d_opcode), 32'(e.op));
          chk("d_size",   32'(tl_o.d_size),   32'(e.size));
          chk("d_source", 32'(tl_o.d_source), 32'(e.src));
          chk("d_data",   tl_o.d_data,        e.data);
          chk("d_error",  32'(tl_o.d_error),  32'(e.err));
        end
        last_data = tl_o.d_data;
        last_opc  = tl_o.d_opcode;
        last_err  = tl_o.d_error;
      end
      if (tl_i.a_valid && tl_o.a_ready) begin
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [31:0] ad;
        logic [3:0]  mk;
        logic [31:0] wm;
        logic [SramAw-1:0] word;
        logic        err, is_data, is_wr;
        exp_t        e;
        op = tl_i.a_opcode; sz = tl_i.a_size; ad = tl_i.a_address; mk = tl_i.a_mask;
        word  = ad[SramAw+1:2];
        is_wr = (op == 3'd0) || (op == 3'd1);
        err   = 1'b0;
`ifdef TLUL_ERR_CHECK_EN
        begin
          int nbytes;
          int win;
          nbytes  = 1 << sz;
          win     = (((1 << nbytes) - 1) << (ad % 4)) & 15;
          err     = !(is_wr || op == 3'd4) || (sz > 2) || ((ad % nbytes) != 0) ||
                    ((int'(mk) & ~win) != 0) || ((op == 3'd0) && (int'(mk) != win));
          is_data = (op == 3'd4);
        end
`else
        is_data = !is_wr;
`endif
        wm = 32'h0;
        for (int b = 0; b < 4; b++) if (mk[b]) wm[8*b +: 8] = 8'hFF;
        acc_req = req;
        chk("req", 32'(req), 32'(!err));
        if (!err) begin
          chk("we", 32'(we), 32'(is_wr));
          chk("addr", 32'(addr), 32'(word));
          if (is_wr) begin
            chk("wmask", wmask, wm);
            chk("wdata", wdata, tl_i.a_data);
            last_wmask = wmask;
            ref_mem[word] = (ref_mem[word] & ~wm) | (tl_i.a_data & wm);
          end
        end
        e.op   = is_data ? 3'd1 : 3'd0;
        e.size = sz;
        e.src  = tl_i.a_source;
        e.data = (is_data && !err) ? ref_mem[word] : 32'h0;
        e.err  = err;
        exp_q.push_back(e);
        n_acc++;
      end else begin
        chk("req_idle", 32'(req), 0);
        if (tl_i.a_valid) n_stall++;
      end
    end
  end

  // Present one request from just after a posedge until it is accepted.
  task automatic send(input logic [2:0] op, input logic [31:0] ad, input logic [1:0] sz,
                      input logic [3:0] mk, input logic [31:0] dat, input logic [7:0] src);
    int  w;
    bit  done;
    w = 0; done = 0;
    tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_address = ad; tl_i.a_size = sz;
    tl_i.a_mask = mk; tl_i.a_data = dat; tl_i.a_source = src;
    tl_i.a_param = 3'($urandom); tl_i.a_user = 16'($urandom);
    while (!done) begin
      @(negedge clk);
      if (tl_o.a_ready) done = 1;
      else if (++w > 200) begin chk("a_timeout", 0, 1); done = 1; end
      @(posedge clk); #1;
    end
    tl_i.a_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin @(negedge clk); #1; w++; end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_req();
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [31:0] off, ad;
    logic [3:0]  win, mk;
    case ($urandom % 3)
      0:       op = 3'd0;
      1:       op = 3'd1;
      default: op = 3'd4;
    endcase
    sz  = 2'($urandom % 3);
    off = ($urandom % 4) & ~((32'd1 << sz) - 1);
    ad  = (($urandom % 16) << 2) + off + (($urandom % 4) << (SramAw + 2));
    win = 4'(((1 << (1 << sz)) - 1) << off);
    mk  = (op == 3'd1) ? (win & 4'($urandom)) : win;
    send(op, ad, sz, mk, $urandom, 8'($urandom));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_stall, base_beat, w;
    bit snd_done, rnd_on;
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    rst = 1'b1;
    init_mem = 1'b1;
    @(posedge clk); #1; init_mem = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_a_ready", 32'(tl_o.a_ready), 1);
    chk("post_rst_d_valid", 32'(tl_o.d_valid), 0);
    @(posedge clk); #1;

    // Put then two-cycle response latency
    send(3'd0, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 8'd3);
    @(negedge clk); chk("t1_lat_t1", 32'(tl_o.d_valid), 0);
    @(negedge clk); chk("t1_lat_t2", 32'(tl_o.d_valid), 1);
    chk("t1_src", 32'(tl_o.d_source), 3);
    chk("t1_opc", 32'(tl_o.d_opcode), 0);
    @(posedge clk); #1;
    drain();

    // Get readback
    send(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd5);
    drain();
    chk("t2_data", last_data, 32'hDEADBEEF);
    chk("t2_opc", 32'(last_opc), 1);

    // Partial write of the upper half-word
    send(3'd1, 32'h12, 2'd1, 4'hC, 32'hABCD0000, 8'd6);
    drain();
    chk("t3_wmask", last_wmask, 32'hFFFF0000);
    send(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd7);
    drain();
    chk("t3_data", last_data, 32'hABCDBEEF);

    // Backpressure: only RspDepth requests fit while D is stalled
    tl_i.d_ready = 1'b0;
    base = n_acc; snd_done = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(3'd4, 32'(i * 4), 2'd2, 4'hF, 32'h0, 8'(16 + i));
        snd_done = 1;
      end
    join_none
    repeat (12) @(negedge clk);
    #1;
    chk("t4_accepted", n_acc - base, RspDepth);
    chk("t4_a_ready", 32'(tl_o.a_ready), 0);
    chk("t4_d_valid", 32'(tl_o.d_valid), 1);
    @(posedge clk); #1; tl_i.d_ready = 1'b1;
    w = 0;
    while (!snd_done && w < 100) begin @(posedge clk); #1; w++; end
    drain();
    chk("t4_total", n_acc - base, 5);

    // Throughput: back-to-back Gets never stall, one beat per cycle
    base_stall = n_stall; base_beat = n_beat; beat_first = -1;
    for (int i = 0; i < 8; i++) send(3'd4, 32'(($urandom % 16) * 4), 2'd2, 4'hF, 32'h0, 8'(32 + i));
    drain();
    chk("t5_stalls", n_stall - base_stall, 0);
    chk("t5_beats", n_beat - base_beat, 8);
    chk("t5_span", beat_last - beat_first, 7);

    // Reset pulse in the middle of a stream
    base = n_acc; snd_done = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(3'd4, 32'(i * 4), 2'd2, 4'hF, 32'h0, 8'(48 + i));
        snd_done = 1;
      end
    join_none
    w = 0;
    while (n_acc - base < 3 && w < 100) begin @(negedge clk); #1; w++; end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_d_valid", 32'(tl_o.d_valid), 0);
    w = 0;
    while (!snd_done && w < 100) begin @(posedge clk); #1; w++; end
    drain();

    // Malformed requests
    send(3'd4, 32'h11, 2'd2, 4'hF, 32'h0, 8'd9);
    drain();
`ifdef TLUL_ERR_CHECK_EN
    chk("t6_req", 32'(acc_req), 0);
    chk("t6_err", 32'(last_err), 1);
    chk("t6_data", last_data, 32'h0);
`else
    chk("t6_req", 32'(acc_req), 1);
    chk("t6_err", 32'(last_err), 0);
`endif
    send(3'd7, 32'h20, 2'd2, 4'hF, 32'h0, 8'd10);
    drain();
`ifdef TLUL_ERR_CHECK_EN
    chk("t6_op7_err", 32'(last_err), 1);
    chk("t6_op7_opc", 32'(last_opc), 0);
`else
    chk("t6_op7_req", 32'(acc_req), 1);
    chk("t6_op7_err", 32'(last_err), 0);
    chk("t6_op7_opc", 32'(last_opc), 1);
`endif

    // Randomized traffic with random D-channel backpressure
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(posedge clk); #1;
        tl_i.d_ready = ($urandom % 4) != 0;
      end
    join_none
    for (int i = 0; i < 120; i++) begin
      rand_req();
      if ($urandom % 4 == 0) begin @(posedge clk); #1; end
    end
    rnd_on = 0;
    @(posedge clk); @(posedge clk); #1;
    tl_i.d_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
